// File: rtl/uart_xcvr.sv
// UART transceiver: valid/ready word interface to serial tx/rx pins, with a configurable
// bit period, data width, parity, stop bits, and a first-word-fall-through RX FIFO.
module uart_xcvr #(
   parameter int CLKS_PER_BIT = 217,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          uart_tx,
   input  logic                          uart_rx,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_perr,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          rx_frame_err,
   output logic                          rx_overrun,
   input  logic                          err_clr
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   // Parity bit that goes on the wire for a given character.
   function automatic logic par_of(input logic [DATA_BITS-1:0] d);
      return (PARITY == 1) ? ~(^d) : (^d);
   endfunction

   // ---------------- transmitter ----------------
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

   tx_state_t              tx_state, tx_state_nxt;
   logic [CNT_W-1:0]       tx_cnt, tx_cnt_nxt;
   logic [2:0]             tx_bit, tx_bit_nxt;
   logic [DATA_BITS-1:0]   tx_shift, tx_shift_nxt;
   logic                   tx_par, tx_par_nxt;
   logic                   tx_line_nxt;
   logic                   tx_bit_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_par   <= 1'b0;
         uart_tx  <= 1'b1;
      end else begin
         tx_state <= tx_state_nxt;
         tx_cnt   <= tx_cnt_nxt;
         tx_bit   <= tx_bit_nxt;
         tx_shift <= tx_shift_nxt;
         tx_par   <= tx_par_nxt;
         uart_tx  <= tx_line_nxt;
      end
   end

   always_comb begin
      tx_state_nxt = tx_state;
      tx_cnt_nxt   = '0;
      tx_bit_nxt   = tx_bit;
      tx_shift_nxt = tx_shift;
      tx_par_nxt   = tx_par;
      tx_ready     = 1'b0;
      tx_line_nxt  = 1'b1;
      tx_bit_end   = (tx_cnt == BIT_LAST);
      if (tx_state != TX_IDLE && !tx_bit_end)
         tx_cnt_nxt = tx_cnt + 1'b1;
      case (tx_state)
         TX_IDLE:  tx_ready = 1'b1;
         TX_START: if (tx_bit_end) begin
            tx_state_nxt = TX_DATA;
            tx_bit_nxt   = '0;
         end
         TX_DATA: if (tx_bit_end) begin
            tx_shift_nxt = tx_shift >> 1;
            if (tx_bit == DATA_LAST) begin
               tx_bit_nxt   = '0;
               tx_state_nxt = (PARITY != 0) ? TX_PARITY : TX_STOP;
            end else begin
               tx_bit_nxt = tx_bit + 1'b1;
            end
         end
         TX_PARITY: if (tx_bit_end) begin
            tx_state_nxt = TX_STOP;
            tx_bit_nxt   = '0;
         end
         TX_STOP: if (tx_bit_end) begin
            if (tx_bit == STOP_LAST) begin
               tx_ready     = 1'b1;
               tx_state_nxt = TX_IDLE;
            end else begin
               tx_bit_nxt = tx_bit + 1'b1;
            end
         end
         default: tx_state_nxt = TX_IDLE;
      endcase
      // Ready in the final stop cycle lets the next start bit follow with no idle gap.
      if (tx_ready && tx_valid) begin
         tx_state_nxt = TX_START;
         tx_shift_nxt = tx_data;
         tx_par_nxt   = par_of(tx_data);
         tx_bit_nxt   = '0;
         tx_cnt_nxt   = '0;
      end
      case (tx_state_nxt)
         TX_START:  tx_line_nxt = 1'b0;
         TX_DATA:   tx_line_nxt = tx_shift_nxt[0];
         TX_PARITY: tx_line_nxt = tx_par_nxt;
         default:   tx_line_nxt = 1'b1;
      endcase
   end

   // ---------------- receiver ----------------
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rx_state_t;

   rx_state_t              rx_state, rx_state_nxt;
   logic [1:0]             rx_sync, rx_prime;
   logic                   rx_armed, rx_s;
   logic [CNT_W-1:0]       rx_cnt, rx_cnt_nxt;
   logic [2:0]             rx_bit, rx_bit_nxt;
   logic [DATA_BITS-1:0]   rx_shift, rx_shift_nxt;
   logic                   rx_pe, rx_pe_nxt;
   logic                   rx_push, ferr_set, rx_samp;

   assign rx_s = rx_sync[1];

   // The line must be seen high after reset before a low can count as a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync  <= 2'b11;
         rx_prime <= 2'b00;
         rx_armed <= 1'b0;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_pe    <= 1'b0;
      end else begin
         rx_sync  <= {rx_sync[0], uart_rx};
         rx_prime <= {rx_prime[0], 1'b1};
         rx_armed <= rx_armed | (rx_prime[1] & rx_s);
         rx_state <= rx_state_nxt;
         rx_cnt   <= rx_cnt_nxt;
         rx_bit   <= rx_bit_nxt;
         rx_shift <= rx_shift_nxt;
         rx_pe    <= rx_pe_nxt;
      end
   end

   always_comb begin
      rx_state_nxt = rx_state;
      rx_cnt_nxt   = rx_cnt + 1'b1;
      rx_bit_nxt   = rx_bit;
      rx_shift_nxt = rx_shift;
      rx_pe_nxt    = rx_pe;
      rx_push      = 1'b0;
      ferr_set     = 1'b0;
      rx_samp      = (rx_cnt == BIT_LAST);
      case (rx_state)
         RX_IDLE: begin
            rx_cnt_nxt = '0;
            if (rx_armed && !rx_s)
               rx_state_nxt = RX_START;
         end
         RX_START: if (rx_cnt == HALF_LAST) begin
            rx_cnt_nxt   = '0;
            rx_bit_nxt   = '0;
            rx_pe_nxt    = 1'b0;
            rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_samp) begin
            rx_cnt_nxt   = '0;
            rx_shift_nxt = {rx_s, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == DATA_LAST) begin
               rx_bit_nxt   = '0;
               rx_state_nxt = (PARITY != 0) ? RX_PARITY : RX_STOP;
            end else begin
               rx_bit_nxt = rx_bit + 1'b1;
            end
         end
         RX_PARITY: if (rx_samp) begin
            rx_cnt_nxt   = '0;
            rx_pe_nxt    = rx_s ^ par_of(rx_shift);
            rx_state_nxt = RX_STOP;
         end
         RX_STOP: if (rx_samp) begin
            rx_cnt_nxt = '0;
            if (rx_s) begin
               rx_push      = 1'b1;
               rx_state_nxt = RX_IDLE;
            end else begin
               ferr_set     = 1'b1;
               rx_state_nxt = RX_WAIT_IDLE;
            end
         end
         RX_WAIT_IDLE: begin
            rx_cnt_nxt = '0;
            if (rx_s)
               rx_state_nxt = RX_IDLE;
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   // ---------------- RX FIFO and status ----------------
   logic [DATA_BITS:0]  mem [FIFO_DEPTH];
   logic [DATA_BITS:0]  head;
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic                full, do_pop, do_push;

   assign full     = (rx_count == CW'(FIFO_DEPTH));
   assign rx_valid = (rx_count != '0);
   assign do_pop   = rx_valid && rx_ready;
   assign do_push  = rx_push && (!full || do_pop);
   assign head     = mem[rd_ptr];
   assign rx_data  = rx_valid ? head[DATA_BITS-1:0] : '0;
   assign rx_perr  = rx_valid ? head[DATA_BITS] : 1'b0;

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= {rx_pe, rx_shift};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         rx_count     <= '0;
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: rx_count <= rx_count;
         endcase
         rx_frame_err <= ferr_set | (rx_frame_err & ~err_clr);
         rx_overrun   <= (rx_push & full & ~do_pop) | (rx_overrun & ~err_clr);
      end
   end

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: three instances (no parity, even-parity loopback, odd parity).
module tb_uart_xcvr;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   // no-parity instance, FIFO depth 4
   logic [7:0] tx_data_n, rx_data_n;
   logic       tx_valid_n, tx_ready_n, utx_n, urx_n, rx_perr_n, rx_valid_n, rx_ready_n;
   logic [2:0] rx_count_n;
   logic       ferr_n, ovr_n, err_clr_n;
   // even-parity loopback instance
   logic [7:0] tx_data_e, rx_data_e;
   logic       tx_valid_e, tx_ready_e, utx_e, rx_perr_e, rx_valid_e, rx_ready_e;
   logic [2:0] rx_count_e;
   logic       ferr_e, ovr_e, err_clr_e;
   // odd-parity instance
   logic [7:0] tx_data_o, rx_data_o;
   logic       tx_valid_o, tx_ready_o, utx_o, urx_o, rx_perr_o, rx_valid_o, rx_ready_o;
   logic [2:0] rx_count_o;
   logic       ferr_o, ovr_o, err_clr_o;

   uart_xcvr #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n),
      .uart_tx(utx_n), .uart_rx(urx_n), .rx_data(rx_data_n), .rx_perr(rx_perr_n),
      .rx_valid(rx_valid_n), .rx_ready(rx_ready_n), .rx_count(rx_count_n),
      .rx_frame_err(ferr_n), .rx_overrun(ovr_n), .err_clr(err_clr_n));

   uart_xcvr #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e),
      .uart_tx(utx_e), .uart_rx(utx_e), .rx_data(rx_data_e), .rx_perr(rx_perr_e),
      .rx_valid(rx_valid_e), .rx_ready(rx_ready_e), .rx_count(rx_count_e),
      .rx_frame_err(ferr_e), .rx_overrun(ovr_e), .err_clr(err_clr_e));

   uart_xcvr #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data_o), .tx_valid(tx_valid_o), .tx_ready(tx_ready_o),
      .uart_tx(utx_o), .uart_rx(urx_o), .rx_data(rx_data_o), .rx_perr(rx_perr_o),
      .rx_valid(rx_valid_o), .rx_ready(rx_ready_o), .rx_count(rx_count_o),
      .rx_frame_err(ferr_o), .rx_overrun(ovr_o), .err_clr(err_clr_o));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives n bits LSB first, 8 clocks each, starting at the current negedge.
   task automatic drive(input int sel, input logic [15:0] bits, input int n);
      logic [15:0] sh;
      for (int i = 0; i < n; i++) begin
         sh = bits >> i;
         if (sel == 0) urx_n = sh[0];
         else          urx_o = sh[0];
         repeat (8) @(negedge clk);
      end
   endtask

   task automatic pop_n();
      @(negedge clk);
      rx_ready_n = 1'b1;
      @(negedge clk);
      rx_ready_n = 1'b0;
   endtask

   task automatic pop_e();
      @(negedge clk);
      rx_ready_e = 1'b1;
      @(negedge clk);
      rx_ready_e = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0]  fr10;
      logic [21:0] fr22;
      int          low_cnt;

      rst_n = 1'b0;
      tx_data_n = '0; tx_valid_n = 1'b0; urx_n = 1'b1; rx_ready_n = 1'b0; err_clr_n = 1'b0;
      tx_data_e = '0; tx_valid_e = 1'b0; rx_ready_e = 1'b0; err_clr_e = 1'b0;
      tx_data_o = '0; tx_valid_o = 1'b0; urx_o = 1'b1; rx_ready_o = 1'b0; err_clr_o = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_uart_tx", 32'(utx_n), 32'd1);
      chk("rst_tx_ready", 32'(tx_ready_n), 32'd1);
      chk("rst_rx_valid", 32'(rx_valid_n), 32'd0);
      chk("rst_rx_count", 32'(rx_count_n), 32'd0);
      chk("rst_rx_data", 32'(rx_data_n), 32'd0);
      chk("rst_rx_perr", 32'(rx_perr_n), 32'd0);
      chk("rst_frame_err", 32'(ferr_n), 32'd0);
      chk("rst_overrun", 32'(ovr_n), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // TX 8N1 0x41: start, 1,0,0,0,0,0,1,0, stop; ready back in the last stop cycle
      fr10 = {1'b1, 8'h41, 1'b0};
      tx_data_n = 8'h41;
      tx_valid_n = 1'b1;
      low_cnt = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (k == 0) tx_valid_n = 1'b0;
         chk("tx41_line", 32'((fr10 >> (k / 8)) & 10'd1), 32'(utx_n) ^ 32'd0);
         if (!tx_ready_n) low_cnt++;
      end
      chk("tx41_ready_low_cycles", 32'(low_cnt), 32'd79);
      chk("tx41_ready_last_stop", 32'(tx_ready_n), 32'd1);
      @(negedge clk);
      chk("tx41_idle_line", 32'(utx_n), 32'd1);
      chk("tx41_idle_ready", 32'(tx_ready_n), 32'd1);

      // Even-parity loopback, 0x5A (parity 0) then 0x5B (parity 1) back to back
      fr22 = {1'b1, 1'b1, 8'h5B, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0};
      tx_data_e = 8'h5A;
      tx_valid_e = 1'b1;
      for (int k = 0; k < 176; k++) begin
         @(negedge clk);
         if (k == 0) tx_data_e = 8'h5B;
         if (k == 88) tx_valid_e = 1'b0;
         chk("lb_line", 32'(utx_e), 32'((fr22 >> (k / 8)) & 22'd1));
         if (k == 87) chk("lb_ready_last_stop", 32'(tx_ready_e), 32'd1);
      end
      for (int i = 0; i < 40 && rx_count_e != 3'd2; i++) @(negedge clk);
      chk("lb_count", 32'(rx_count_e), 32'd2);
      chk("lb_data0", 32'(rx_data_e), 32'h5A);
      chk("lb_perr0", 32'(rx_perr_e), 32'd0);
      pop_e();
      chk("lb_data1", 32'(rx_data_e), 32'h5B);
      chk("lb_perr1", 32'(rx_perr_e), 32'd0);
      chk("lb_count1", 32'(rx_count_e), 32'd1);
      pop_e();
      chk("lb_empty", 32'(rx_valid_e), 32'd0);
      chk("lb_ferr", 32'(ferr_e), 32'd0);

      // Odd parity, 0x5A with parity bit 0 (correct would be 1)
      drive(1, {5'b0, 1'b1, 1'b0, 8'h5A, 1'b0}, 11);
      for (int i = 0; i < 40 && !rx_valid_o; i++) @(negedge clk);
      chk("odd_valid", 32'(rx_valid_o), 32'd1);
      chk("odd_data", 32'(rx_data_o), 32'h5A);
      chk("odd_perr", 32'(rx_perr_o), 32'd1);
      chk("odd_ferr", 32'(ferr_o), 32'd0);

      // 2-cycle glitch is a false start
      urx_n = 1'b0;
      repeat (2) @(negedge clk);
      urx_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("glitch_count", 32'(rx_count_n), 32'd0);
      chk("glitch_ferr", 32'(ferr_n), 32'd0);
      chk("glitch_ovr", 32'(ovr_n), 32'd0);

      // 0x33 with stop bit 0, then line held low
      drive(0, {6'b0, 1'b0, 8'h33, 1'b0}, 10);
      repeat (30) @(negedge clk);
      chk("ferr_count", 32'(rx_count_n), 32'd0);
      chk("ferr_set", 32'(ferr_n), 32'd1);
      urx_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("ferr_sticky", 32'(ferr_n), 32'd1);
      chk("ferr_nopush", 32'(rx_valid_n), 32'd0);
      err_clr_n = 1'b1;
      @(negedge clk);
      err_clr_n = 1'b0;
      chk("ferr_clr", 32'(ferr_n), 32'd0);

      // Overrun: five characters into a 4-entry FIFO
      for (int d = 1; d <= 5; d++)
         drive(0, {6'b0, 1'b1, 8'(d), 1'b0}, 10);
      repeat (4) @(negedge clk);
      chk("ovr_count", 32'(rx_count_n), 32'd4);
      chk("ovr_flag", 32'(ovr_n), 32'd1);
      for (int d = 1; d <= 4; d++) begin
         chk("ovr_pop_data", 32'(rx_data_n), 32'(d));
         pop_n();
      end
      chk("ovr_empty_count", 32'(rx_count_n), 32'd0);
      chk("ovr_empty_valid", 32'(rx_valid_n), 32'd0);
      err_clr_n = 1'b1;
      @(negedge clk);
      err_clr_n = 1'b0;
      chk("ovr_clr", 32'(ovr_n), 32'd0);

      // Full FIFO, pop in the same cycle as the push of 0x14
      for (int d = 16; d <= 19; d++)
         drive(0, {6'b0, 1'b1, 8'(d), 1'b0}, 10);
      chk("same_full", 32'(rx_count_n), 32'd4);
      drive(0, {7'b0, 8'h14, 1'b0}, 9);
      urx_n = 1'b1;
      repeat (6) @(negedge clk);
      rx_ready_n = 1'b1;
      @(negedge clk);
      rx_ready_n = 1'b0;
      repeat (10) @(negedge clk);
      chk("same_no_ovr", 32'(ovr_n), 32'd0);
      chk("same_count", 32'(rx_count_n), 32'd4);
      for (int d = 17; d <= 20; d++) begin
         chk("same_pop_data", 32'(rx_data_n), 32'(d));
         pop_n();
      end

      // Reset mid-frame, with rx held low through reset
      tx_data_n = 8'h00;
      tx_valid_n = 1'b1;
      @(negedge clk);
      tx_valid_n = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_pre_ready", 32'(tx_ready_n), 32'd0);
      chk("rst_pre_line", 32'(utx_n), 32'd0);
      urx_n = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_line", 32'(utx_n), 32'd1);
      chk("rst_async_ready", 32'(tx_ready_n), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (120) @(negedge clk);
      chk("rst_low_line_count", 32'(rx_count_n), 32'd0);
      chk("rst_low_line_ferr", 32'(ferr_n), 32'd0);
      urx_n = 1'b1;
      repeat (5) @(negedge clk);
      drive(0, {6'b0, 1'b1, 8'h7E, 1'b0}, 10);
      repeat (4) @(negedge clk);
      chk("post_rst_count", 32'(rx_count_n), 32'd1);
      chk("post_rst_data", 32'(rx_data_n), 32'h7E);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
